spi_arbiter: RTL

Round-robin arbiter and transaction sequencer that shares one SPI master between `NUM_REQ` requesters. It accepts one request per grant, latches the header and write data into stable registers, and drives the master's `start`, `master_rd_wr`, `master_address` and `master_out_data` for exactly one frame. It then returns the master's read byte to the granted requester. It sits between the client blocks and the SPI master, on the master's `mclk` domain.

---
 rtl/spi_arbiter_if.sv | 31 +++
 rtl/spi_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/spi_arbiter_if.sv
// Requester-side and SPI-master-side signal bundle for spi_arbiter.
// slave: arbiter view; master: view of the clients and SPI master driving it.
interface spi_arbiter_if #(
   parameter int unsigned NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ-1:0]   req_ready;
   logic [NUM_REQ-1:0]   req_rd_wr;
   logic [7*NUM_REQ-1:0] req_addr;
   logic [8*NUM_REQ-1:0] req_wdata;
   logic [NUM_REQ-1:0]   rsp_valid;
   logic [7:0]           rsp_rdata;
   logic                 busy;
   logic                 start;
   logic                 master_rd_wr;
   logic [6:0]           master_address;
   logic [7:0]           master_out_data;
   logic [7:0]           master_in_data;

   modport slave (
      input  req_valid, req_rd_wr, req_addr, req_wdata, master_in_data,
      output req_ready, rsp_valid, rsp_rdata, busy, start,
             master_rd_wr, master_address, master_out_data
   );

   modport master (
      output req_valid, req_rd_wr, req_addr, req_wdata, master_in_data,
      input  req_ready, rsp_valid, rsp_rdata, busy, start,
             master_rd_wr, master_address, master_out_data
   );
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ requesters, one frame per grant.
// Define SPI_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no pointer).
module spi_arbiter #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned XFER_CYCLES = 17,
   parameter int unsigned GAP_CYCLES  = 3
) (
   input logic          i_mclk,
   input logic          i_reset,
   spi_arbiter_if.slave bus
);

   localparam int unsigned CntMax = (XFER_CYCLES > GAP_CYCLES) ? XFER_CYCLES : GAP_CYCLES;
   localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
   localparam int unsigned GntW   = $clog2(NUM_REQ);

   typedef enum logic [1:0] {StIdle, StXfer, StGap, StResp} state_e;

   state_e              r_state, w_state_d;
   logic [CntW-1:0]     r_cnt, w_cnt_d;
   logic [GntW-1:0]     r_grant, w_grant_d;
   logic                r_rd_wr, w_rd_wr_d;
   logic [6:0]          r_addr, w_addr_d;
   logic [7:0]          r_wdata, w_wdata_d;
   logic [7:0]          r_rdata, w_rdata_d;
   logic [NUM_REQ-1:0]  w_req_ready;
   logic                w_found;
   logic [GntW-1:0]     w_gidx;

`ifdef SPI_ARB_FIXED_PRIO_EN
   always_comb begin
      w_found = 1'b0;
      w_gidx  = '0;
      for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
         if (bus.req_valid[i]) begin
            w_found = 1'b1;
            w_gidx  = GntW'(i);
         end
      end
   end
`else
   logic [GntW-1:0] r_last, w_last_d;

   // Search starts one past the last grant and wraps, so nobody wins twice while others wait.
   always_comb begin
      int idx;
      idx     = 0;
      w_found = 1'b0;
      w_gidx  = '0;
      for (int k = 1; k <= int'(NUM_REQ); k++) begin
         idx = (int'(r_last) + k) % int'(NUM_REQ);
         if (!w_found && bus.req_valid[idx]) begin
            w_found = 1'b1;
            w_gidx  = GntW'(idx);
         end
      end
   end

   always_ff @(posedge i_mclk or posedge i_reset) begin
      if (i_reset) r_last <= GntW'(NUM_REQ - 1);
      else         r_last <= w_last_d;
   end
`endif

   always_comb begin
      w_state_d   = r_state;
      w_cnt_d     = r_cnt;
      w_grant_d   = r_grant;
      w_rd_wr_d   = r_rd_wr;
      w_addr_d    = r_addr;
      w_wdata_d   = r_wdata;
      w_rdata_d   = r_rdata;
      w_req_ready = '0;
`ifndef SPI_ARB_FIXED_PRIO_EN
      w_last_d    = r_last;
`endif
      unique case (r_state)
         StIdle: begin
            if (w_found) begin
               w_req_ready[w_gidx] = 1'b1;
               w_grant_d = w_gidx;
               w_rd_wr_d = bus.req_rd_wr[w_gidx];
               w_addr_d  = bus.req_addr[7*w_gidx +: 7];
               w_wdata_d = bus.req_wdata[8*w_gidx +: 8];
               w_cnt_d   = CntW'(XFER_CYCLES - 1);
               w_state_d = StXfer;
`ifndef SPI_ARB_FIXED_PRIO_EN
               w_last_d  = w_gidx;
`endif
            end
         end
         StXfer: begin
            if (r_cnt == '0) begin
               w_cnt_d   = CntW'(GAP_CYCLES - 1);
               w_state_d = StGap;
            end else begin
               w_cnt_d = r_cnt - 1'b1;
            end
         end
         StGap: begin
            if (r_cnt == '0) begin
               w_rdata_d = r_rd_wr ? bus.master_in_data : 8'h00;
               w_state_d = StResp;
            end else begin
               w_cnt_d = r_cnt - 1'b1;
            end
         end
         StResp:  w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_mclk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_grant <= '0;
         r_rd_wr <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         r_grant <= w_grant_d;
         r_rd_wr <= w_rd_wr_d;
         r_addr  <= w_addr_d;
         r_wdata <= w_wdata_d;
         r_rdata <= w_rdata_d;
      end
   end

   // Grant is combinational from IDLE, so it must be masked while reset is held.
   assign bus.req_ready       = i_reset ? '0 : w_req_ready;
   assign bus.rsp_valid       = (r_state == StResp) ? (NUM_REQ'(1) << r_grant) : '0;
   assign bus.rsp_rdata       = r_rdata;
   assign bus.busy            = (r_state != StIdle);
   assign bus.start           = (r_state == StXfer);
   assign bus.master_rd_wr    = r_rd_wr;
   assign bus.master_address  = r_addr;
   assign bus.master_out_data = r_wdata;

endmodule
